// File: rtl/booth_radix4_mult_seq.sv
// Sequential radix-4 Booth multiplier, one digit retired per clock.
// Define BOOTH_SIGNED_EN for two's-complement operands; default build is unsigned.
module booth_radix4_mult_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned PW = 2 * WIDTH;
`ifdef BOOTH_SIGNED_EN
  localparam int unsigned BW   = WIDTH;
  localparam int unsigned NDIG = WIDTH / 2;
`else
  localparam int unsigned BW   = WIDTH + 2;
  localparam int unsigned NDIG = WIDTH / 2 + 1;
`endif
  localparam int unsigned CW = $clog2(NDIG);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q;
  logic [PW-1:0]   m_q;
  logic [BW:0]     b_q;
  logic [PW-1:0]   acc_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic            done_q;
  logic [PW-1:0]   product_q;

  logic [PW-1:0]   a_ext_c;
  logic [BW:0]     b_ext_c;
  logic [PW-1:0]   term_c;
  logic [PW-1:0]   acc_d;
  logic            last_c;

  // Operand extension; b carries an implicit b[-1]=0 in its LSB.
  always_comb begin
`ifdef BOOTH_SIGNED_EN
    a_ext_c = {{WIDTH{a[WIDTH-1]}}, a};
    b_ext_c = {b, 1'b0};
`else
    a_ext_c = {{WIDTH{1'b0}}, a};
    b_ext_c = {2'b00, b, 1'b0};
`endif
  end

  // m_q is pre-weighted by 4^i, so the term needs no further shifting.
  always_comb begin
    term_c = '0;
    case (b_q[2:0])
      3'b001, 3'b010: term_c = m_q;
      3'b011:         term_c = {m_q[PW-2:0], 1'b0};
      3'b100:         term_c = -{m_q[PW-2:0], 1'b0};
      3'b101, 3'b110: term_c = -m_q;
      default:        term_c = '0;
    endcase
    acc_d  = acc_q + term_c;
    last_c = (cnt_q == CW'(NDIG - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      m_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            m_q     <= a_ext_c;
            b_q     <= b_ext_c;
            acc_q   <= '0;
            cnt_q   <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          m_q   <= {m_q[PW-3:0], 2'b00};
          b_q   <= {2'b00, b_q[BW:2]};
          cnt_q <= cnt_q + CW'(1);
          if (last_c) begin
            state_q   <= DONE;
            product_q <= acc_d;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule
